// File: rtl/lc3_dcache_param_if.sv
// Bus bundle between the LC3 MemAccess stage, the data cache and external data memory.
// Handshakes: rrqst/rrdy and wrqst/wacpt transfer on a cycle where both are high, and the
// requester holds its request and address/data stable until then; a fill word moves when
// rdrdy (mdout valid) and rdacpt are high together; complete is a one-cycle strobe.
interface lc3_dcache_param_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              macc;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              inv;
  logic [DATA_W-1:0] dout;
  logic              complete;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdin;
  logic [DATA_W-1:0] mdout;
  logic              rrqst;
  logic              rrdy;
  logic              rdrdy;
  logic              rdacpt;
  logic              wrqst;
  logic              wacpt;

  modport slave (
    input  macc, rd, addr, din, inv, mdout, rrdy, rdrdy, wacpt,
    output dout, complete, maddr, mdin, rrqst, rdacpt, wrqst
  );

  modport master (
    output macc, rd, addr, din, inv, mdout, rrdy, rdrdy, wacpt,
    input  dout, complete, maddr, mdin, rrqst, rdacpt, wrqst
  );
endinterface

// File: rtl/lc3_dcache_param.sv
// Parametrised direct-mapped, write-through, no-write-allocate data cache for the LC3
// pipeline, with whole-cache invalidate and saturating read hit/miss counters.
module lc3_dcache_param #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  lc3_dcache_param_if.slave        bus,
  output logic [15:0]              hit_cnt,
  output logic [15:0]              miss_cnt,
  output logic [2:0]               stateDbg
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, RREQ, RFILL, WREQ, DONE} state_t;

  state_t state, stateNext;

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic [OFFSET_W-1:0] count;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tagArr  [LINES];
  logic [DATA_W-1:0]   dataArr [LINES][WORDS];
  logic                hit;
  logic                lastBeat;

  assign tag      = bus.addr[ADDR_W-1 -: TAG_W];
  assign index    = bus.addr[OFFSET_W +: INDEX_W];
  assign offset   = bus.addr[OFFSET_W-1:0];
  assign hit      = valid[index] && (tagArr[index] == tag);
  assign lastBeat = &count;
  assign stateDbg = state;

  always_comb begin
    stateNext    = state;
    bus.complete = 1'b0;
    bus.dout     = '0;
    bus.rrqst    = 1'b0;
    bus.rdacpt   = 1'b0;
    bus.wrqst    = 1'b0;
    bus.maddr    = '0;
    bus.mdin     = '0;
    case (state)
      IDLE: begin
        // inv wins over a same-cycle request, which is then retried next cycle
        if (!bus.inv && bus.macc) begin
          if (bus.rd) begin
            if (hit) begin
              bus.complete = 1'b1;
              bus.dout     = dataArr[index][offset];
            end else begin
              stateNext = RREQ;
            end
          end else begin
            stateNext = WREQ;
          end
        end
      end
      RREQ: begin
        bus.rrqst = 1'b1;
        bus.maddr = {tag, index, {OFFSET_W{1'b0}}};
        if (bus.rrdy) stateNext = RFILL;
      end
      RFILL: begin
        bus.rdacpt = bus.rdrdy;
        if (bus.rdrdy && lastBeat) stateNext = DONE;
      end
      WREQ: begin
        bus.wrqst = 1'b1;
        bus.maddr = bus.addr;
        bus.mdin  = bus.din;
        if (bus.wacpt) stateNext = DONE;
      end
      DONE: begin
        bus.complete = 1'b1;
        if (bus.rd) bus.dout = dataArr[index][offset];
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (bus.inv) begin
            valid <= '0;
          end else if (bus.macc && bus.rd) begin
            if (hit) begin
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
              if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        RREQ: if (bus.rrdy) count <= '0;
        RFILL: begin
          if (bus.rdrdy) begin
            count <= count + OFFSET_W'(1);
            // the line becomes visible only once its final word has landed
            if (lastBeat) valid[index] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; a line is meaningless until its valid bit is set.
  always_ff @(posedge clock) begin
    if (state == RFILL && bus.rdrdy) begin
      dataArr[index][count] <= bus.mdout;
      if (lastBeat) tagArr[index] <= tag;
    end
    if (state == WREQ && bus.wacpt && hit) dataArr[index][offset] <= bus.din;
  end
endmodule

// File: tb/tb_lc3_dcache_param.sv
// Directed bench for lc3_dcache_param: fills, hits, write-through, stalls, reset and invalidate.
module tb_lc3_dcache_param;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] hitCnt;
  logic [15:0] missCnt;
  logic [2:0]  stateDbg;
  logic [15:0] beat = 16'd0;
  logic [15:0] memBase = 16'hA000;
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          lat;
  int          wrqCnt;

  lc3_dcache_param_if #(.ADDR_W(16), .DATA_W(16)) bus();

  lc3_dcache_param dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .hit_cnt  (hitCnt),
    .miss_cnt (missCnt),
    .stateDbg (stateDbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // memory model: fill word k of a block reads memBase + k
  assign bus.mdout = memBase + beat;
  always @(posedge clock) begin
    if (reset || (bus.rrqst && bus.rrdy)) beat <= 16'd0;
    else if (bus.rdacpt && bus.rdrdy) beat <= beat + 16'd1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic driveReq(input logic r, input logic [15:0] a, input logic [15:0] d);
    bus.macc = 1'b1;
    bus.rd   = r;
    bus.addr = a;
    bus.din  = d;
  endtask

  task automatic waitComplete(input int maxCyc, output int cyc);
    cyc = 0;
    settle();
    while (!bus.complete && cyc < maxCyc) begin
      tick();
      settle();
      cyc++;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkRead(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    chk(tag, {16'd0, bus.dout}, {16'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.macc = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.din = '0; bus.inv = 1'b0;
    bus.rrdy = 1'b1; bus.rdrdy = 1'b1; bus.wacpt = 1'b1;
    reset = 1'b1;
    tick(); tick();
    settle();
    chk("rst_outs", {bus.complete, bus.rrqst, bus.wrqst, bus.rdacpt}, 32'h0);
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_maddr_mdin", {bus.maddr, bus.mdin}, 32'h0);
    chk("rst_cnts", {hitCnt, missCnt}, 32'h0);
    tick();
    reset = 1'b0;

    // read miss on 0x3005 with immediate handshakes
    tick();
    driveReq(1'b1, 16'h3005, 16'h0);
    exp_q.push_back(16'hA001);
    settle();
    chk("miss_c0", {bus.complete, bus.rrqst}, 32'h0);
    tick(); settle();
    chk("miss_c1_rrqst", bus.rrqst, 32'h1);
    chk("miss_c1_maddr", bus.maddr, 32'h3004);
    for (int c = 2; c <= 5; c++) begin
      tick(); settle();
      chk("miss_fill", {bus.rdacpt, bus.complete}, 32'h2);
    end
    tick(); settle();
    chk("miss_c6_complete", bus.complete, 32'h1);
    chkRead("miss_c6_dout");
    tick();
    bus.macc = 1'b0;
    settle();
    chk("miss_cnts", {hitCnt, missCnt}, 32'h0000_0001);

    // read hit on 0x3007 completes combinationally
    driveReq(1'b1, 16'h3007, 16'h0);
    exp_q.push_back(16'hA003);
    settle();
    chk("hit_complete", {bus.complete, bus.rrqst}, 32'h2);
    chkRead("hit_dout");
    tick();
    bus.macc = 1'b0;
    settle();
    chk("hit_cnts", {hitCnt, missCnt}, 32'h0001_0001);

    // write hit 0xBEEF -> 0x3006 with wacpt held off three cycles
    bus.wacpt = 1'b0;
    wrqCnt = 0;
    driveReq(1'b0, 16'h3006, 16'hBEEF);
    settle();
    chk("wr_c0", {bus.complete, bus.wrqst}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) bus.wacpt = 1'b1;
      settle();
      if (bus.wrqst) wrqCnt++;
      if (i == 1) chk("wr_bus", {bus.maddr, bus.mdin}, 32'h3006_BEEF);
    end
    tick();
    bus.wacpt = 1'b0;
    settle();
    chk("wr_done", {bus.complete, bus.wrqst}, 32'h2);
    chk("wr_dout", bus.dout, 32'h0);
    chk("wr_held", wrqCnt, 32'd4);
    tick();
    bus.macc = 1'b0;
    bus.wacpt = 1'b1;
    driveReq(1'b1, 16'h3006, 16'h0);
    exp_q.push_back(16'hBEEF);
    settle();
    chk("wr_rehit", bus.complete, 32'h1);
    chkRead("wr_rehit_dout");
    tick();
    bus.macc = 1'b0;
    settle();
    chk("wr_rehit_cnts", {hitCnt, missCnt}, 32'h0002_0001);

    // write miss on 0x5000 does not allocate
    tick();
    driveReq(1'b0, 16'h5000, 16'h1234);
    waitComplete(20, lat);
    chk("wmiss_lat", lat, 32'd2);
    tick();
    bus.macc = 1'b0;
    tick();
    driveReq(1'b1, 16'h5000, 16'h0);
    exp_q.push_back(16'hA000);
    waitComplete(20, lat);
    chk("wmiss_read_lat", lat, 32'd6);
    chkRead("wmiss_read_dout");
    tick();
    bus.macc = 1'b0;
    settle();
    chk("wmiss_cnts", {hitCnt, missCnt}, 32'h0002_0002);

    // fill with rdrdy 1,0,1,0 then reset mid-fill
    tick();
    driveReq(1'b1, 16'h7002, 16'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.rdrdy = (c == 2 || c == 4);
      settle();
      if (c == 2) chk("stall_acpt_on", bus.rdacpt, 32'h1);
      if (c == 3) chk("stall_acpt_off", {bus.rdacpt, bus.complete}, 32'h0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.macc = 1'b0;
    bus.rdrdy = 1'b1;
    settle();
    chk("midrst_state", {29'd0, stateDbg}, 32'h0);
    chk("midrst_cnts", {hitCnt, missCnt}, 32'h0);

    // re-read misses; alternating rdrdy stalls add one cycle each
    tick();
    driveReq(1'b1, 16'h7002, 16'h0);
    exp_q.push_back(16'hA002);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.rdrdy = (c % 2 == 0);
      settle();
      if (bus.complete) begin
        lat = c;
        break;
      end
    end
    chk("reread_lat", lat, 32'd9);
    chkRead("reread_dout");
    tick();
    bus.macc = 1'b0;
    bus.rdrdy = 1'b1;
    settle();
    chk("reread_cnts", {hitCnt, missCnt}, 32'h0000_0001);

    // invalidate alongside a would-be hit
    tick();
    bus.inv = 1'b1;
    driveReq(1'b1, 16'h7002, 16'h0);
    exp_q.push_back(16'hA002);
    settle();
    chk("inv_c0", {bus.complete, bus.rrqst}, 32'h0);
    tick();
    bus.inv = 1'b0;
    settle();
    chk("inv_c1", {bus.complete, bus.rrqst}, 32'h0);
    tick();
    settle();
    chk("inv_c2_rrqst", bus.rrqst, 32'h1);
    chk("inv_cnts", {hitCnt, missCnt}, 32'h0000_0002);
    tick();
    waitComplete(20, lat);
    chk("inv_lat", lat, 32'd4);
    chkRead("inv_dout");
    tick();
    bus.macc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
